// File: rtl/dequant_shared_if.sv
// dequant_shared_if: tile/handshake bundle for the shared dequantizer.
// The master drives the start request, quantization parameters and input tile.
// The slave returns the dequantized tile, the valid pulse and busy.
interface dequant_shared_if #(
  parameter int ROWS      = 32,
  parameter int COLS      = 16,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 32
);
  logic                        start;
  logic signed [15:0]          scale;
  logic        [4:0]           shift_amount;
  logic signed [IN_WIDTH-1:0]  zero_point;
  logic signed [IN_WIDTH-1:0]  data_in  [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] data_out [ROWS][COLS];
  logic                        valid;
  logic                        busy;

  modport master (
    output start, scale, shift_amount, zero_point, data_in,
    input  data_out, valid, busy
  );

  modport slave (
    input  start, scale, shift_amount, zero_point, data_in,
    output data_out, valid, busy
  );
endinterface

// File: rtl/dequant_shared.sv
// dequant_shared: time-multiplexed int8 -> fixed-point tile dequantizer.
// DEQ_UNITS two-stage lanes sweep the ROWSxCOLS tile in B batches:
//   stage 1: p = (in - zp) * scale, stage 2: rounded arithmetic shift + saturate,
//   then write into the output buffer, which is published to data_out in DONE.
// Optional feature macro: DEQUANT_ZERO_POINT_EN (zero-point subtraction).
// Without it the zero_point input is ignored and no zero-point logic is built.
module dequant_shared #(
  parameter int ROWS      = 32,
  parameter int COLS      = 16,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int DEQ_UNITS = 64
) (
  input  logic             clk,
  input  logic             reset,
  dequant_shared_if.slave  bus
);

  localparam int TOTAL = ROWS * COLS;
  localparam int B     = (TOTAL + DEQ_UNITS - 1) / DEQ_UNITS;
  localparam int PW    = IN_WIDTH + 17;
  localparam int IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int IDXW  = $clog2(B * DEQ_UNITS) + 1;
  localparam int CW    = (B > 2) ? $clog2(B) : 1;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (ACC_WIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (ACC_WIDTH - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROCESS,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic [CW-1:0]               r_cnt;
  logic                        r_valid;
  logic                        r_busy;
  logic signed [ACC_WIDTH-1:0] r_data_out [ROWS][COLS];

  logic signed [IN_WIDTH-1:0]  r_in [TOTAL];
  logic signed [15:0]          r_scale;
  logic        [4:0]           r_sh;
`ifdef DEQUANT_ZERO_POINT_EN
  logic signed [IN_WIDTH-1:0]  r_zp;
`endif

  logic signed [ACC_WIDTH-1:0] r_obuf [TOTAL];

  logic                        r_v1   [DEQ_UNITS];
  logic signed [PW-1:0]        r_p1   [DEQ_UNITS];
  logic [IW-1:0]               r_idx1 [DEQ_UNITS];
  logic                        r_v2   [DEQ_UNITS];
  logic signed [ACC_WIDTH-1:0] r_r2   [DEQ_UNITS];
  logic [IW-1:0]               r_idx2 [DEQ_UNITS];

  logic [IDXW-1:0]             w_idx  [DEQ_UNITS];
  logic                        w_ok   [DEQ_UNITS];
  logic [IW-1:0]               w_ridx [DEQ_UNITS];
  logic signed [PW-1:0]        w_p    [DEQ_UNITS];
  logic signed [ACC_WIDTH-1:0] w_r    [DEQ_UNITS];

  // Stage 1 arithmetic: widen to IN_WIDTH+1, optionally remove the zero point, scale.
`ifdef DEQUANT_ZERO_POINT_EN
  function automatic logic signed [PW-1:0] mul_stage(
    input logic signed [IN_WIDTH-1:0] x,
    input logic signed [IN_WIDTH-1:0] zp,
    input logic signed [15:0]         sc
  );
    logic signed [IN_WIDTH:0] d;
    logic signed [PW-1:0]     a;
    logic signed [PW-1:0]     b;
    d = {x[IN_WIDTH-1], x} - {zp[IN_WIDTH-1], zp};
    a = PW'(d);
    b = PW'(sc);
    return a * b;
  endfunction
`else
  function automatic logic signed [PW-1:0] mul_stage(
    input logic signed [IN_WIDTH-1:0] x,
    input logic signed [15:0]         sc
  );
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = PW'(x);
    b = PW'(sc);
    return a * b;
  endfunction
`endif

  // Stage 2 arithmetic is done in 64 bits so the rounding constant for large
  // shifts (up to 2^30) never overflows before saturation.
  function automatic logic signed [ACC_WIDTH-1:0] round_sat(
    input logic signed [PW-1:0] p,
    input logic [4:0]           sh
  );
    logic signed [63:0] w;
    w = 64'(p);
    if (sh != 5'd0) begin
      w = (w + (64'sd1 <<< (sh - 5'd1))) >>> sh;
    end
    if (w > SAT_MAX) begin
      w = SAT_MAX;
    end else if (w < SAT_MIN) begin
      w = SAT_MIN;
    end
    return ACC_WIDTH'(w);
  endfunction

  // Control FSM: batch sweep, pipeline drain, then publish the finished tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < COLS; j++) begin
          r_data_out[i][j] <= '0;
        end
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_PROCESS;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_PROCESS: begin
          if (r_cnt == CW'(B - 1)) begin
            r_cnt   <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == CW'(1)) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          for (int unsigned i = 0; i < ROWS; i++) begin
            for (int unsigned j = 0; j < COLS; j++) begin
              r_data_out[i][j] <= r_obuf[i*COLS + j];
            end
          end
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Capture the tile and parameters on the accepting edge; held for the whole tile.
  always_ff @(posedge clk) begin
    if (!reset && r_state == S_IDLE && bus.start) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        for (int unsigned j = 0; j < COLS; j++) begin
          r_in[i*COLS + j] <= bus.data_in[i][j];
        end
      end
      r_scale <= bus.scale;
      r_sh    <= bus.shift_amount;
`ifdef DEQUANT_ZERO_POINT_EN
      r_zp    <= bus.zero_point;
`endif
    end
  end

  // Per-lane element selection and combinational stage arithmetic.
  always_comb begin
    for (int unsigned u = 0; u < DEQ_UNITS; u++) begin
      w_idx[u]  = IDXW'(r_cnt) * IDXW'(DEQ_UNITS) + IDXW'(u);
      w_ok[u]   = (r_state == S_PROCESS) && (w_idx[u] < IDXW'(TOTAL));
      w_ridx[u] = w_ok[u] ? IW'(w_idx[u]) : '0;
`ifdef DEQUANT_ZERO_POINT_EN
      w_p[u]    = mul_stage(r_in[w_ridx[u]], r_zp, r_scale);
`else
      w_p[u]    = mul_stage(r_in[w_ridx[u]], r_scale);
`endif
      w_r[u]    = round_sat(r_p1[u], r_sh);
    end
  end

  // Lane valid tags; cleared by reset so no partial tile is ever written back.
  always_ff @(posedge clk) begin
    for (int unsigned u = 0; u < DEQ_UNITS; u++) begin
      if (reset) begin
        r_v1[u] <= 1'b0;
        r_v2[u] <= 1'b0;
      end else begin
        r_v1[u] <= w_ok[u];
        r_v2[u] <= r_v1[u];
      end
    end
  end

  // Lane data pipeline registers (payload only, qualified by the tags).
  always_ff @(posedge clk) begin
    for (int unsigned u = 0; u < DEQ_UNITS; u++) begin
      r_p1[u]   <= w_p[u];
      r_idx1[u] <= w_ridx[u];
      r_r2[u]   <= w_r[u];
      r_idx2[u] <= r_idx1[u];
    end
  end

  // Writeback of tagged lane results into the output buffer.
  always_ff @(posedge clk) begin
    for (int unsigned u = 0; u < DEQ_UNITS; u++) begin
      if (!reset && r_v2[u]) begin
        r_obuf[r_idx2[u]] <= r_r2[u];
      end
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;

endmodule
